alctrl_ram_mp: RTL and testbench

Multi-port active-list control RAM with configurable write and read port counts. Lanes and partitions can be gated at run time. A built-in clear sequencer replaces the instantaneous reset of the fixed-width version with a row-by-row sweep. It sits in the active-list control path: issue lanes write completion/control bits, and commit lanes read them combinationally. The sequencer also re-clears any partition that is re-activated, and gates `ramReady_o` until each sweep completes.

---
 rtl/alctrl_pkg.sv | 20 ++
 rtl/alctrl_clear_fsm.sv | 129 ++++++++++++
 rtl/alctrl_ram_mp.sv | 122 ++++++++++++
 tb/tb_alctrl_ram_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alctrl_pkg.sv
// Shared types, constants and helpers for the multi-port active-list control RAM.
package alctrl_pkg;

    // Clear-sequencer states: full sweep after reset, normal operation, partition sweep.
    typedef enum logic [1:0] {
        ALC_CLEAR  = 2'd0,
        ALC_READY  = 2'd1,
        ALC_PCLEAR = 2'd2
    } alc_state_t;

    // Clear value selectors for the RESET_VAL parameter.
    localparam int ALC_RESET_ZERO = 32'd0;
    localparam int ALC_RESET_SEQ  = 32'd1;

    // Partition index of a row address: its top bits above the per-partition row offset.
    function automatic int alc_part_of(input int addr, input int row_bits);
        return addr >> row_bits;
    endfunction

endpackage

// File: rtl/alctrl_clear_fsm.sv
// Clear sequencer for alctrl_ram_mp: sweeps every row after reset and
// re-sweeps each partition when it is powered back up (1->0 on its gate).
// Holds the state, row counter, pending-partition mask and gate history.
module alctrl_clear_fsm
    import alctrl_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int INDEX     = 4,
    parameter int NUM_PARTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PARTS-1:0] partitionGated_i,
    output logic                 clr_en,
    output logic [INDEX-1:0]     clr_addr,
    output logic                 ramReady_o
);

    localparam int PART_BITS = $clog2(NUM_PARTS);
    localparam int PART_W    = (PART_BITS > 0) ? PART_BITS : 1;
    localparam int ROW_BITS  = INDEX - PART_BITS;
    localparam int RPP       = DEPTH / NUM_PARTS;
    localparam logic [INDEX-1:0] ROW_MASK = INDEX'(RPP - 1);

    alc_state_t           state_r;
    logic [INDEX-1:0]     cnt_r;
    logic [NUM_PARTS-1:0] pend_r;
    logic [NUM_PARTS-1:0] prev_gate_r;
    logic [PART_W-1:0]    cur_part_r;
    logic                 ram_ready_r;

    logic [NUM_PARTS-1:0] fall_s;
    logic [NUM_PARTS-1:0] new_pend_s;
    logic [NUM_PARTS-1:0] next_mask_s;
    logic                 sweep_end_s;
    logic [PART_W-1:0]    low_s;
    logic [INDEX-1:0]     clr_addr_s;

    // Pending mask update: add newly un-gated partitions, drop any that are gated again,
    // and decide whether the current partition sweep ends (finished or abandoned).
    always_comb begin
        fall_s      = prev_gate_r & ~partitionGated_i;
        new_pend_s  = (pend_r | fall_s) & ~partitionGated_i;
        if (state_r == ALC_PCLEAR) begin
            sweep_end_s = ~new_pend_s[cur_part_r] | (cnt_r == ROW_MASK);
        end else begin
            sweep_end_s = 1'b0;
        end
        for (int i = 0; i < NUM_PARTS; i++) begin
            next_mask_s[i] = new_pend_s[i] & ~(sweep_end_s & (PART_W'(i) == cur_part_r));
        end
        low_s = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            low_s = next_mask_s[i] ? PART_W'(i) : low_s;
        end
    end

    // Address of the row being cleared this cycle.
    always_comb begin
        case (state_r)
            ALC_CLEAR:  clr_addr_s = cnt_r;
            ALC_PCLEAR: clr_addr_s = (INDEX'(cur_part_r) << ROW_BITS) | (cnt_r & ROW_MASK);
            default:    clr_addr_s = '0;
        endcase
    end

    // Sequencer state machine with registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ALC_CLEAR;
            cnt_r       <= '0;
            pend_r      <= '0;
            prev_gate_r <= '1;
            cur_part_r  <= '0;
            ram_ready_r <= 1'b0;
        end else begin
            prev_gate_r <= partitionGated_i;
            case (state_r)
                ALC_CLEAR: begin
                    pend_r <= '0;
                    if (cnt_r == INDEX'(DEPTH - 1)) begin
                        state_r     <= ALC_READY;
                        cnt_r       <= '0;
                        ram_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + INDEX'(1'b1);
                    end
                end
                ALC_READY: begin
                    pend_r <= new_pend_s;
                    if (|new_pend_s) begin
                        state_r     <= ALC_PCLEAR;
                        cur_part_r  <= low_s;
                        cnt_r       <= '0;
                        ram_ready_r <= 1'b0;
                    end else begin
                        ram_ready_r <= 1'b1;
                    end
                end
                ALC_PCLEAR: begin
                    if (sweep_end_s) begin
                        pend_r <= next_mask_s;
                        cnt_r  <= '0;
                        if (|next_mask_s) begin
                            cur_part_r <= low_s;
                        end else begin
                            state_r     <= ALC_READY;
                            ram_ready_r <= 1'b1;
                        end
                    end else begin
                        pend_r <= new_pend_s;
                        cnt_r  <= cnt_r + INDEX'(1'b1);
                    end
                end
                default: begin
                    state_r     <= ALC_CLEAR;
                    cnt_r       <= '0;
                    pend_r      <= '0;
                    ram_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en     = (state_r != ALC_READY);
    assign clr_addr   = clr_addr_s;
    assign ramReady_o = ram_ready_r;

endmodule

// File: rtl/alctrl_ram_mp.sv
// Multi-port active-list control RAM: issue lanes write, commit lanes read
// combinationally. Lanes and partitions can be power-gated; a clear sequencer
// sweeps rows after reset and on partition re-activation.
// Optional macro ALCTRL_RD_BYPASS_EN: same-cycle write-to-read forwarding.
module alctrl_ram_mp
    import alctrl_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int INDEX        = 4,
    parameter int WIDTH        = 8,
    parameter int NUM_WR_PORTS = 4,
    parameter int NUM_RD_PORTS = 4,
    parameter int NUM_PARTS    = 4,
    parameter int RESET_VAL    = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WR_PORTS-1:0]         wrEn_i,
    input  logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_i,
    input  logic [NUM_RD_PORTS*INDEX-1:0]   addr_i,
    output logic [NUM_RD_PORTS*WIDTH-1:0]   data_o,
    input  logic [NUM_WR_PORTS-1:0]         writePortGated_i,
    input  logic [NUM_RD_PORTS-1:0]         readPortGated_i,
    input  logic [NUM_PARTS-1:0]            partitionGated_i,
    output logic                            ramReady_o
);

    localparam int PART_BITS = $clog2(NUM_PARTS);
    localparam int PART_W    = (PART_BITS > 0) ? PART_BITS : 1;
    localparam int ROW_BITS  = INDEX - PART_BITS;

    logic [WIDTH-1:0]        mem_r     [DEPTH];
    logic [INDEX-1:0]        wr_addr_s [NUM_WR_PORTS];
    logic [WIDTH-1:0]        wr_data_s [NUM_WR_PORTS];
    logic [PART_W-1:0]       wr_part_s [NUM_WR_PORTS];
    logic [NUM_WR_PORTS-1:0] wr_acc_s;
    logic [INDEX-1:0]        rd_addr_s [NUM_RD_PORTS];
    logic [PART_W-1:0]       rd_part_s [NUM_RD_PORTS];
    logic [WIDTH-1:0]        rd_data_s [NUM_RD_PORTS];

    logic                    clr_en_s;
    logic [INDEX-1:0]        clr_addr_s;
    logic [WIDTH-1:0]        clr_val_s;
    logic                    ram_ready_s;

    alctrl_clear_fsm #(
        .DEPTH     (DEPTH),
        .INDEX     (INDEX),
        .NUM_PARTS (NUM_PARTS)
    ) u_clear_fsm (
        .clk              (clk),
        .reset            (reset),
        .partitionGated_i (partitionGated_i),
        .clr_en           (clr_en_s),
        .clr_addr         (clr_addr_s),
        .ramReady_o       (ram_ready_s)
    );

    genvar g;
    for (g = 0; g < NUM_WR_PORTS; g++) begin : g_wr
        assign wr_addr_s[g] = addrWr_i[g*INDEX +: INDEX];
        assign wr_data_s[g] = dataWr_i[g*WIDTH +: WIDTH];
        assign wr_part_s[g] = PART_W'(alc_part_of(int'(wr_addr_s[g]), ROW_BITS));
        assign wr_acc_s[g]  = wrEn_i[g] & ~writePortGated_i[g] &
                              ~partitionGated_i[wr_part_s[g]] & ram_ready_s;
    end

    for (g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
        assign rd_addr_s[g]               = addr_i[g*INDEX +: INDEX];
        assign rd_part_s[g]               = PART_W'(alc_part_of(int'(rd_addr_s[g]), ROW_BITS));
        assign data_o[g*WIDTH +: WIDTH]   = rd_data_s[g];
    end

    // Value written by the clear sequencer: zero, or the row index itself.
    always_comb begin
        if (RESET_VAL == ALC_RESET_SEQ) begin
            clr_val_s = WIDTH'(clr_addr_s);
        end else begin
            clr_val_s = '0;
        end
    end

    // Array update: sweep rows while clearing, otherwise accepted writes with the
    // highest-index port landing last so it wins a same-row collision.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem_r[clr_addr_s] <= clr_val_s;
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_acc_s[p]) begin
                    mem_r[wr_addr_s[p]] <= wr_data_s[p];
                end
            end
        end
    end

    // Read muxes: gated lanes and gated partitions read as zero.
    always_comb begin
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            rd_data_s[r] = '0;
            if (readPortGated_i[r]) begin
                rd_data_s[r] = '0;
            end else if (partitionGated_i[rd_part_s[r]]) begin
                rd_data_s[r] = '0;
            end else begin
                rd_data_s[r] = mem_r[rd_addr_s[r]];
`ifdef ALCTRL_RD_BYPASS_EN
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    rd_data_s[r] = (wr_acc_s[p] && (wr_addr_s[p] == rd_addr_s[r])) ?
                                   wr_data_s[p] : rd_data_s[r];
                end
`else
                rd_data_s[r] = rd_data_s[r];
`endif
            end
        end
    end

    assign ramReady_o = ram_ready_s;

endmodule

// File: tb/tb_alctrl_ram_mp.sv
// Randomized scoreboard bench for alctrl_ram_mp (RESET_VAL=1, default sizes).
module tb_alctrl_ram_mp;

    localparam int DEPTH = 16;
    localparam int INDEX = 4;
    localparam int WIDTH = 8;
    localparam int NW    = 4;
    localparam int NR    = 4;
    localparam int NP    = 4;
    localparam int RPP   = DEPTH / NP;

    localparam int M_FULL = 0;
    localparam int M_RDY  = 1;
    localparam int M_PART = 2;

    logic                  clk;
    logic                  reset;
    logic [NW-1:0]         wrEn_i;
    logic [NW*INDEX-1:0]   addrWr_i;
    logic [NW*WIDTH-1:0]   dataWr_i;
    logic [NR*INDEX-1:0]   addr_i;
    logic [NR*WIDTH-1:0]   data_o;
    logic [NW-1:0]         wpg;
    logic [NR-1:0]         rpg;
    logic [NP-1:0]         pg;
    logic                  ready_o;

    alctrl_ram_mp #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
        .NUM_WR_PORTS(NW), .NUM_RD_PORTS(NR), .NUM_PARTS(NP), .RESET_VAL(1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wrEn_i           (wrEn_i),
        .addrWr_i         (addrWr_i),
        .dataWr_i         (dataWr_i),
        .addr_i           (addr_i),
        .data_o           (data_o),
        .writePortGated_i (wpg),
        .readPortGated_i  (rpg),
        .partitionGated_i (pg),
        .ramReady_o       (ready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard entries: port -1 means ramReady_o.
    typedef struct {
        int         cyc;
        int         port;
        logic [7:0] exp;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int misc    = 0;

    // Behavioural model: rows, pending partitions, queue of rows still to clear.
    logic [7:0] mem_m [DEPTH];
    int         mode_m = M_FULL;
    bit         ready_m = 1'b0;
    bit [NP-1:0] pend_m = '0;
    bit [NP-1:0] prev_m = '1;
    int         cur_m = 0;
    int         sweep_q[$];

    function automatic int wr_addr(int p);
        return int'(addrWr_i[p*INDEX +: INDEX]);
    endfunction

    function automatic bit accepted(int p);
        return (mode_m == M_RDY) && wrEn_i[p] && !wpg[p] && !pg[wr_addr(p) / RPP];
    endfunction

    function automatic logic [7:0] exp_read(int r);
        int a;
        logic [7:0] v;
        a = int'(addr_i[r*INDEX +: INDEX]);
        if (rpg[r]) return 8'h00;
        if (pg[a / RPP]) return 8'h00;
        v = mem_m[a];
`ifdef ALCTRL_RD_BYPASS_EN
        for (int p = 0; p < NW; p++)
            if (accepted(p) && wr_addr(p) == a) v = dataWr_i[p*WIDTH +: WIDTH];
`endif
        return v;
    endfunction

    task automatic start_next();
        cur_m = 0;
        for (int i = NP - 1; i >= 0; i--) if (pend_m[i]) cur_m = i;
        sweep_q = {};
        for (int k = 0; k < RPP; k++) sweep_q.push_back(cur_m * RPP + k);
        mode_m  = M_PART;
        ready_m = 1'b0;
    endtask

    task automatic model_edge();
        bit [NP-1:0] fall;
        int r;
        if (reset) begin
            mode_m = M_FULL; ready_m = 1'b0; pend_m = '0; prev_m = '1; cur_m = 0;
            sweep_q = {};
            for (int i = 0; i < DEPTH; i++) sweep_q.push_back(i);
        end else begin
            fall   = prev_m & ~pg;
            prev_m = pg;
            if (mode_m == M_FULL) begin
                r = sweep_q.pop_front();
                mem_m[r] = 8'(r);
                if (sweep_q.size() == 0) begin mode_m = M_RDY; ready_m = 1'b1; end
            end else if (mode_m == M_RDY) begin
                for (int p = 0; p < NW; p++)
                    if (accepted(p)) mem_m[wr_addr(p)] = dataWr_i[p*WIDTH +: WIDTH];
                pend_m = (pend_m | fall) & ~pg;
                if (pend_m != 0) start_next();
            end else begin
                r = sweep_q.pop_front();
                mem_m[r] = 8'(r);
                pend_m = (pend_m | fall) & ~pg;
                if (!pend_m[cur_m]) sweep_q = {};
                else if (sweep_q.size() == 0) pend_m[cur_m] = 1'b0;
                if (sweep_q.size() == 0) begin
                    if (pend_m != 0) start_next();
                    else begin mode_m = M_RDY; ready_m = 1'b1; end
                end
            end
        end
    endtask

    // One bench cycle: queue expectations for the current inputs, then advance.
    task automatic cycle();
        exp_q.push_back('{cyc, -1, {7'b0, ready_m}});
        if (!reset && ready_m)
            for (int r = 0; r < NR; r++) exp_q.push_back('{cyc, r, exp_read(r)});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_wr(int p, int a, int d);
        wrEn_i[p] = 1'b1;
        addrWr_i[p*INDEX +: INDEX] = INDEX'(a);
        dataWr_i[p*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    task automatic set_rd(int r, int a);
        addr_i[r*INDEX +: INDEX] = INDEX'(a);
    endtask

    // Monitor: compare every queued expectation for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (e.port < 0) act = {7'b0, ready_o};
            else act = data_o[e.port*WIDTH +: WIDTH];
            if (act !== e.exp) begin
                misc++;
                $display("FAIL %s cyc=%0d got=%02h expected=%02h",
                         (e.port < 0) ? "ramReady" : $sformatf("data_o[%0d]", e.port),
                         e.cyc, act, e.exp);
            end
        end
    end

    initial begin
        int pi;
        reset = 1'b1; wrEn_i = '0; addrWr_i = '0; dataWr_i = '0; addr_i = '0;
        wpg = '0; rpg = '0; pg = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        @(posedge clk); model_edge(); #1;
        cycle(); cycle();
        reset = 1'b0;
        // Reset sweep; row 5 reads 5 once ready.
        set_rd(0, 5); set_rd(1, 0); set_rd(2, 15); set_rd(3, 10);
        for (int i = 0; i < 18; i++) cycle();
        // Ports 0 and 3 collide on row 7.
        set_wr(0, 7, 8'hAA); set_wr(3, 7, 8'h55); cycle();
        wrEn_i = '0; set_rd(0, 7); cycle();
        // Partition 2: gated write dropped, ungate re-clears rows 8..11.
        set_wr(0, 9, 8'h99); cycle(); wrEn_i = '0;
        pg = 4'b0100; set_wr(0, 9, 8'h3C); set_rd(1, 9); cycle();
        wrEn_i = '0; cycle(); cycle();
        pg = 4'b0000; cycle();
        for (int i = 0; i < 5; i++) cycle();
        for (int r = 0; r < NR; r++) set_rd(r, 8 + r);
        cycle();
        // Gated write lane and gated read lane.
        wpg = 4'b0010; rpg = 4'b0100; set_wr(1, 0, 8'hFF); set_rd(0, 0); set_rd(2, 0); cycle();
        wrEn_i = '0; cycle();
        wpg = '0; rpg = '0;
        // Read row 4 while writing it.
        set_wr(1, 4, 8'h77); set_rd(0, 4); cycle();
        wrEn_i = '0; cycle();
        // Reset during the second partition-sweep cycle.
        pg = 4'b0010; cycle(); cycle();
        pg = 4'b0000; cycle(); cycle();
        reset = 1'b1; cycle(); cycle();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            wrEn_i   = NW'($urandom());
            addrWr_i = (NW*INDEX)'($urandom());
            dataWr_i = (NW*WIDTH)'($urandom());
            addr_i   = (NR*INDEX)'($urandom());
            wpg = ($urandom_range(0, 7) == 0) ? NW'($urandom()) : '0;
            rpg = ($urandom_range(0, 7) == 0) ? NR'($urandom()) : '0;
            if ($urandom_range(0, 15) == 0) begin
                pi = $urandom_range(0, NP - 1);
                pg[pi] = ~pg[pi];
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0; wrEn_i = '0; pg = '0;
        for (int i = 0; i < 40; i++) cycle();
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            misc++;
            $display("FAIL leftover got=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
